// File: rtl/game_flow_ctrl.sv
// Brick-breaker game-flow controller: stages, lives and skill arbitration.
// Optional pause support is built in when GAME_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int NUM_STAGES        = 3,
    parameter int LIFE_INIT         = 5,
    parameter int SKILL_MAX         = 3,
    parameter int SKILL_REGEN_TICKS = 200,
    parameter int CLEAR_TICKS       = 40,
    parameter int NUM_SKILLS        = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tick,
    input  logic                               start_press,
    input  logic                               pause_press,
    input  logic                               ball_lost,
    input  logic                               bricks_empty,
    input  logic [NUM_SKILLS-1:0]              skill_req,
    input  logic [NUM_SKILLS-1:0]              skill_active,
    output logic [2:0]                         state,
    output logic [2:0]                         stage_idx,
    output logic [7:0]                         life_point,
    output logic [$clog2(SKILL_MAX+1)-1:0]     skill_point,
    output logic [NUM_SKILLS-1:0]              skill_grant,
    output logic                               stage_load
);

    localparam int SPW = $clog2(SKILL_MAX + 1);
    localparam int RW  = $clog2(SKILL_REGEN_TICKS);
    localparam int CW  = (CLEAR_TICKS > 1) ? $clog2(CLEAR_TICKS) : 1;

    localparam logic [SPW-1:0] SP_MAX    = SPW'(SKILL_MAX);
    localparam logic [7:0]     LIFE_LOAD = 8'(LIFE_INIT);
    localparam logic [2:0]     LAST_STG  = 3'(NUM_STAGES - 1);
    localparam logic [RW-1:0]  REGEN_END = RW'(SKILL_REGEN_TICKS - 1);
    localparam logic [CW-1:0]  CLEAR_END = CW'(CLEAR_TICKS - 1);

    typedef enum logic [2:0] {
        S_MENU  = 3'd0,
        S_WIN   = 3'd1,
        S_LOSE  = 3'd2,
        S_PLAY  = 3'd3,
        S_LOAD  = 3'd4,
        S_CLEAR = 3'd5,
        S_PAUSE = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            stage_q, stage_d;
    logic [7:0]            life_q, life_d;
    logic [SPW-1:0]        sp_q, sp_d;
    logic [RW-1:0]         regen_q, regen_d;
    logic [CW-1:0]         clear_q, clear_d;
    logic [NUM_SKILLS-1:0] grant_q, grant_d;
    logic                  load_q, load_d;

    logic [NUM_SKILLS-1:0] cand;
    logic                  grant_any;
    logic                  regen_hit;

`ifndef GAME_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_press;
`endif

    assign cand = skill_req & ~skill_active;

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        life_d    = life_q;
        sp_d      = sp_q;
        regen_d   = regen_q;
        clear_d   = clear_q;
        grant_d   = '0;
        grant_any = 1'b0;
        regen_hit = 1'b0;

        unique case (state_q)
            S_MENU: begin
                if (start_press) begin
                    state_d = S_LOAD;
                    stage_d = 3'd0;
                    life_d  = LIFE_LOAD;
                    sp_d    = '0;
                    regen_d = '0;
                end
            end
            S_LOAD: state_d = S_PLAY;
            S_PLAY: begin
                // Lowest set bit of the candidate set wins
                if (cand != '0 && sp_q != '0) begin
                    grant_d   = cand & (~cand + NUM_SKILLS'(1));
                    grant_any = 1'b1;
                end
                if (tick) begin
                    if (regen_q == REGEN_END) begin
                        regen_d   = '0;
                        regen_hit = 1'b1;
                    end else begin
                        regen_d = regen_q + 1'b1;
                    end
                end
                if (grant_any && !regen_hit)
                    sp_d = sp_q - 1'b1;
                else if (!grant_any && regen_hit && sp_q != SP_MAX)
                    sp_d = sp_q + 1'b1;

                if (bricks_empty) begin
                    state_d = S_CLEAR;
                    clear_d = '0;
                end else if (ball_lost) begin
                    if (life_q > 8'd1) begin
                        life_d = life_q - 8'd1;
                    end else begin
                        life_d  = 8'd0;
                        state_d = S_LOSE;
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (pause_press) begin
                    state_d = S_PAUSE;
                end
`endif
            end
            S_CLEAR: begin
                if (start_press || (tick && clear_q == CLEAR_END)) begin
                    if (stage_q == LAST_STG) begin
                        state_d = S_WIN;
                    end else begin
                        stage_d = stage_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end else if (tick) begin
                    clear_d = clear_q + 1'b1;
                end
            end
            S_WIN, S_LOSE: begin
                if (start_press)
                    state_d = S_MENU;
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (pause_press)
                    state_d = S_PLAY;
            end
`endif
            default: state_d = S_MENU;
        endcase

        load_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_MENU;
            stage_q <= 3'd0;
            life_q  <= LIFE_LOAD;
            sp_q    <= '0;
            regen_q <= '0;
            clear_q <= '0;
            grant_q <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            life_q  <= life_d;
            sp_q    <= sp_d;
            regen_q <= regen_d;
            clear_q <= clear_d;
            grant_q <= grant_d;
            load_q  <= load_d;
        end
    end

    assign state       = state_q;
    assign stage_idx   = stage_q;
    assign life_point  = life_q;
    assign skill_point = sp_q;
    assign skill_grant = grant_q;
    assign stage_load  = load_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with default parameters.
// Pause vectors are included when GAME_PAUSE_EN is defined.
module tb_game_flow_ctrl;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start_press;
    logic       pause_press;
    logic       ball_lost;
    logic       bricks_empty;
    logic [2:0] skill_req;
    logic [2:0] skill_active;
    logic [2:0] state;
    logic [2:0] stage_idx;
    logic [7:0] life_point;
    logic [1:0] skill_point;
    logic [2:0] skill_grant;
    logic       stage_load;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] max_sp;

    game_flow_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .start_press  (start_press),
        .pause_press  (pause_press),
        .ball_lost    (ball_lost),
        .bricks_empty (bricks_empty),
        .skill_req    (skill_req),
        .skill_active (skill_active),
        .state        (state),
        .stage_idx    (stage_idx),
        .life_point   (life_point),
        .skill_point  (skill_point),
        .skill_grant  (skill_grant),
        .stage_load   (stage_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; start_press = 1'b0; pause_press = 1'b0;
        ball_lost = 1'b0; bricks_empty = 1'b0;
        skill_req = '0; skill_active = '0;

        // Reset
        step(); step();
        chk("rst_state", state, 0);
        chk("rst_life", life_point, 5);
        chk("rst_sp", skill_point, 0);
        chk("rst_grant", skill_grant, 0);
        chk("rst_load", stage_load, 0);
        rst = 1'b1;
        step();
        chk("idle_state", state, 0);

        // Start, LOAD for one cycle, then lose all lives
        start_press = 1'b1; step(); start_press = 1'b0;
        chk("load_state", state, 4);
        chk("load_pulse", stage_load, 1);
        chk("load_stage", stage_idx, 0);
        step();
        chk("play_state", state, 3);
        chk("load_done", stage_load, 0);
        for (int i = 4; i >= 1; i--) begin
            ball_lost = 1'b1; step(); ball_lost = 1'b0;
            chk("life_dec", life_point, i);
            chk("life_state", state, 3);
        end
        ball_lost = 1'b1; step(); ball_lost = 1'b0;
        chk("life_zero", life_point, 0);
        chk("lose_state", state, 2);
        ball_lost = 1'b1; step(); ball_lost = 1'b0;
        chk("lose_no_uf", life_point, 0);
        start_press = 1'b1; step(); start_press = 1'b0;
        chk("lose_menu", state, 0);
        chk("lose_life_hold", life_point, 0);

        // Reset mid-PLAY
        start_press = 1'b1; step(); start_press = 1'b0;
        chk("restart_life", life_point, 5);
        step();
        ball_lost = 1'b1; step(); ball_lost = 1'b0;
        chk("mid_life", life_point, 4);
        rst = 1'b0; step(); rst = 1'b1;
        chk("midrst_state", state, 0);
        chk("midrst_life", life_point, 5);
        chk("midrst_load", stage_load, 0);

        // New game for regen / skills / stages
        start_press = 1'b1; step(); start_press = 1'b0;
        step();
        chk("play2_state", state, 3);

`ifdef GAME_PAUSE_EN
        pause_press = 1'b1; step(); pause_press = 1'b0;
        chk("pause_state", state, 6);
        tick = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ball_lost = (i == 150);
            skill_req = (i == 151) ? 3'b001 : 3'b000;
            step();
        end
        tick = 1'b0; ball_lost = 1'b0; skill_req = '0;
        chk("pause_sp", skill_point, 0);
        chk("pause_life", life_point, 5);
        chk("pause_grant", skill_grant, 0);
        pause_press = 1'b1; step(); pause_press = 1'b0;
        chk("unpause_state", state, 3);
`else
        pause_press = 1'b1; step(); pause_press = 1'b0;
        chk("nopause_state", state, 3);
`endif

        // Regeneration and saturation
        tick = 1'b1;
        for (int i = 0; i < 199; i++) step();
        chk("regen_199", skill_point, 0);
        step();
        chk("regen_200", skill_point, 1);
        max_sp = 2'd0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (skill_point > max_sp) max_sp = skill_point;
        end
        tick = 1'b0;
        chk("regen_sat", skill_point, 3);
        chk("regen_max", max_sp, 3);

        // Skill arbitration
        skill_req = 3'b001; step(); skill_req = '0;
        chk("grant_a", skill_grant, 3'b001);
        chk("grant_a_sp", skill_point, 2);
        skill_req = 3'b111; skill_active = 3'b001; step();
        skill_req = '0; skill_active = '0;
        chk("grant_b", skill_grant, 3'b010);
        chk("grant_b_sp", skill_point, 1);
        step();
        chk("grant_pulse", skill_grant, 0);
        skill_req = 3'b010; skill_active = 3'b010; step();
        skill_req = '0; skill_active = '0;
        chk("grant_active", skill_grant, 0);
        chk("grant_active_sp", skill_point, 1);
        skill_req = 3'b001; step(); skill_req = '0;
        chk("grant_c_sp", skill_point, 0);
        skill_req = 3'b001; step(); skill_req = '0;
        chk("grant_empty", skill_grant, 0);
        chk("grant_empty_sp", skill_point, 0);

        // Grant vs regen on the same edge
        tick = 1'b1;
        for (int i = 0; i < 199; i++) step();
        skill_req = 3'b001; step(); skill_req = '0;
        chk("regen_nogrant", skill_grant, 0);
        chk("regen_nogrant_sp", skill_point, 1);
        for (int i = 0; i < 199; i++) step();
        skill_req = 3'b100; step(); skill_req = '0;
        tick = 1'b0;
        chk("both_grant", skill_grant, 3'b100);
        chk("both_sp", skill_point, 1);

        // Stage clear and advance
        bricks_empty = 1'b1; ball_lost = 1'b1; step(); ball_lost = 1'b0;
        chk("clear_state", state, 5);
        chk("clear_life", life_point, 5);
        tick = 1'b1;
        for (int i = 0; i < 39; i++) step();
        chk("clear_39", state, 5);
        bricks_empty = 1'b0;
        step();
        tick = 1'b0;
        chk("clear_exit", state, 4);
        chk("clear_stage", stage_idx, 1);
        chk("clear_load", stage_load, 1);
        chk("clear_sp_keep", skill_point, 1);
        step();
        chk("stage1_play", state, 3);
        bricks_empty = 1'b1; step(); bricks_empty = 1'b0;
        start_press = 1'b1; step(); start_press = 1'b0;
        chk("skip_state", state, 4);
        chk("skip_stage", stage_idx, 2);
        step();
        bricks_empty = 1'b1; step(); bricks_empty = 1'b0;
        chk("clear2_state", state, 5);
        start_press = 1'b1; step(); start_press = 1'b0;
        chk("win_state", state, 1);
        chk("win_stage", stage_idx, 2);
        chk("win_life", life_point, 5);
        start_press = 1'b1; step(); start_press = 1'b0;
        chk("win_menu", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
